// File: rtl/code_lock_controller_pkg.sv
// Shared constants for the digit code lock: digit width, default parameters,
// FSM state encoding and a small saturating counter helper.
package code_lock_controller_pkg;

  localparam int DIGIT_W = 3;

  localparam int DEF_CODE_LEN       = 4;
  localparam int DEF_OPEN_CYCLES    = 8;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 16;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [2:0]         state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ENTER   = 3'd1;
  localparam state_t ST_CHECK   = 3'd2;
  localparam state_t ST_OPEN    = 3'd3;
  localparam state_t ST_PROG    = 3'd4;
  localparam state_t ST_LOCKOUT = 3'd5;

  // Failure counter increment that holds at its maximum instead of wrapping.
  function automatic logic [1:0] sat_inc2(input logic [1:0] value);
    return (value == 2'd3) ? value : value + 2'd1;
  endfunction

endpackage

// File: rtl/code_lock_controller_if.sv
// Keypad-side signal bundle of the code lock; master drives digits and
// controls, slave (the lock) returns status and its FSM state for debug.
interface code_lock_controller_if;
  import code_lock_controller_pkg::*;

  // Handshake: digit_valid is a one-cycle strobe. A digit transfers on a rising
  // edge where digit_valid && ready; with ready low the strobe is dropped and
  // has no effect. There is no backpressure queue: the keypad never retries.
  digit_t     digit_in;
  logic       digit_valid;
  logic       clear;
  logic       prog_mode;
  logic       ready;
  logic       unlock;
  logic       alarm;
  logic [1:0] fail_count;
  state_t     fsm_state;

  modport master (
    output digit_in, digit_valid, clear, prog_mode,
    input  ready, unlock, alarm, fail_count, fsm_state
  );

  modport slave (
    input  digit_in, digit_valid, clear, prog_mode,
    output ready, unlock, alarm, fail_count, fsm_state
  );

endinterface

// File: rtl/code_lock_controller_comparador.sv
// Combinational bitwise equality of two 3-bit digits; the lock owns exactly
// one of these and shares it across every digit position.
module comparador_digito_3bits
  import code_lock_controller_pkg::*;
(
  input  digit_t a,
  input  digit_t b,
  output logic   eq
);

  assign eq = (a == b);

endmodule

// File: rtl/code_lock_controller.sv
// Digit code lock: collects CODE_LEN digits, opens on a match, counts failed
// attempts into a timed lockout, and allows reprogramming while open.
module code_lock_controller
  import code_lock_controller_pkg::*;
#(
  parameter int CODE_LEN       = DEF_CODE_LEN,
  parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  code_lock_controller_if.slave  lock_if
);

  localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CODE_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [TMR_W-1:0] OPEN_LOAD  = TMR_W'(OPEN_CYCLES);
  localparam logic [TMR_W-1:0] LOCK_LOAD  = TMR_W'(LOCKOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [1:0]       FAIL_LIMIT = 2'(MAX_FAILS);

  state_t                             state;
  state_t                             state_nxt;
  logic   [IDX_W-1:0]                 idx;
  logic   [TMR_W-1:0]                 timer;
  logic                               mismatch;
  logic   [1:0]                       fail_count;
  logic   [CODE_LEN-1:0][DIGIT_W-1:0] stored;

  logic       digit_eq;
  logic       at_last;
  logic [1:0] fail_inc;
  logic       ready_c;
  logic       unlock_nxt;
  logic       alarm_nxt;
  logic       unlock_q;
  logic       alarm_q;

  comparador_digito_3bits u_cmp (
    .a  (lock_if.digit_in),
    .b  (stored[idx]),
    .eq (digit_eq)
  );

  assign at_last  = (idx == LAST_IDX);
  assign fail_inc = sat_inc2(fail_count);

  // State register; unlock/alarm are registered copies of the output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      unlock_q <= unlock_nxt;
      alarm_q  <= alarm_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!lock_if.clear && lock_if.digit_valid) state_nxt = ST_ENTER;
      end
      ST_ENTER: begin
        if (lock_if.clear)                        state_nxt = ST_IDLE;
        else if (lock_if.digit_valid && at_last)  state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (!mismatch)                    state_nxt = ST_OPEN;
        else if (fail_inc == FAIL_LIMIT)  state_nxt = ST_LOCKOUT;
        else                              state_nxt = ST_IDLE;
      end
      ST_OPEN: begin
        if (lock_if.prog_mode)   state_nxt = ST_PROG;
        else if (timer == '0)    state_nxt = ST_IDLE;
      end
      ST_PROG: begin
        if (lock_if.digit_valid && at_last) state_nxt = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (timer == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The timer is loaded in CHECK, so unlock/alarm follow one edge after the
  // state change and stay high for exactly the programmed number of cycles.
  always_comb begin
    ready_c    = (state == ST_IDLE) || (state == ST_ENTER) || (state == ST_PROG);
    unlock_nxt = (state == ST_OPEN) && !lock_if.prog_mode && (timer != '0);
    alarm_nxt  = (state == ST_LOCKOUT) && (timer != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      timer      <= '0;
      mismatch   <= 1'b0;
      fail_count <= 2'd0;
      stored     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lock_if.clear) begin
            idx      <= '0;
            mismatch <= 1'b0;
          end else if (lock_if.digit_valid) begin
            idx      <= IDX_ONE;
            mismatch <= !digit_eq;
          end
        end
        ST_ENTER: begin
          if (lock_if.clear) begin
            idx      <= '0;
            mismatch <= 1'b0;
          end else if (lock_if.digit_valid) begin
            mismatch <= mismatch | !digit_eq;
            idx      <= at_last ? '0 : idx + IDX_ONE;
          end
        end
        ST_CHECK: begin
          mismatch <= 1'b0;
          if (!mismatch) begin
            fail_count <= 2'd0;
            timer      <= OPEN_LOAD;
          end else begin
            fail_count <= fail_inc;
            if (fail_inc == FAIL_LIMIT) timer <= LOCK_LOAD;
          end
        end
        ST_OPEN: begin
          if (lock_if.prog_mode) begin
            idx   <= '0;
            timer <= '0;
          end else if (timer != '0) begin
            timer <= timer - TMR_ONE;
          end
        end
        ST_PROG: begin
          if (lock_if.digit_valid) begin
            stored[idx] <= lock_if.digit_in;
            idx         <= at_last ? '0 : idx + IDX_ONE;
          end
        end
        ST_LOCKOUT: begin
          if (timer != '0) timer      <= timer - TMR_ONE;
          else             fail_count <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign lock_if.ready      = ready_c;
  assign lock_if.unlock     = unlock_q;
  assign lock_if.alarm      = alarm_q;
  assign lock_if.fail_count = fail_count;
  assign lock_if.fsm_state  = state;

endmodule

// File: tb/tb_code_lock_controller.sv
// Randomized bench for code_lock_controller: a code/fail-count model predicts
// each attempt's outcome and the exact open/lockout windows.
module tb_code_lock_controller;

  localparam int L      = 4;
  localparam int OPEN_C = 8;
  localparam int MAXF   = 3;
  localparam int LOCK_C = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  code_lock_controller_if lock_if();

  code_lock_controller #(
    .CODE_LEN       (L),
    .OPEN_CYCLES    (OPEN_C),
    .MAX_FAILS      (MAXF),
    .LOCKOUT_CYCLES (LOCK_C)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lock_if (lock_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model / scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [L*3-1:0] ref_code;
  int             ref_fails;
  logic [1:0]     exp_q[$];

  function automatic logic [L*3-1:0] mk(input logic [2:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [L*3-1:0] wrong_code();
    logic [L*3-1:0] c;
    do c = 12'($urandom); while (c == ref_code);
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic quiet();
    lock_if.digit_valid = 1'b0;
    lock_if.clear       = 1'b0;
  endtask

  task automatic noise();
    lock_if.digit_valid = 1'($urandom);
    lock_if.digit_in    = 3'($urandom);
    lock_if.clear       = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_digit(input logic [2:0] d);
    lock_if.digit_in    = d;
    lock_if.digit_valid = 1'b1;
    @(negedge clk);
    lock_if.digit_valid = 1'b0;
    lock_if.digit_in    = 3'($urandom);
  endtask

  task automatic enter_code(input logic [L*3-1:0] code, input int gap_max);
    for (int i = 0; i < L; i++) begin
      idle(int'($urandom_range(0, gap_max)));
      send_digit(code[i*3 +: 3]);
    end
  endtask

  task automatic pulse_clear();
    lock_if.clear = 1'b1;
    @(negedge clk);
    lock_if.clear = 1'b0;
  endtask

  // Called on the falling edge right after the last digit was sampled; follows
  // the attempt to its end (full open window, full lockout, or back to idle).
  task automatic check_outcome(input logic [L*3-1:0] code, input string tag);
    bit opens;
    bit locks;
    opens = (code == ref_code);
    if (opens) ref_fails = 0;
    else       ref_fails = ref_fails + 1;
    locks = !opens && (ref_fails == MAXF);
    exp_q.push_back(2'(ref_fails));

    n_checks++; if (lock_if.ready !== 1'b0) $display("FAIL %s check_ready: got %b want 0", tag, lock_if.ready); else n_pass++;
    n_checks++; if (lock_if.unlock !== 1'b0) $display("FAIL %s early_unlock: got %b want 0", tag, lock_if.unlock); else n_pass++;
    noise();
    @(negedge clk);
    n_checks++; if (lock_if.fail_count !== exp_q[0]) $display("FAIL %s fail_count: got %0d want %0d", tag, lock_if.fail_count, exp_q[0]); else n_pass++;
    void'(exp_q.pop_front());
    n_checks++; if (lock_if.unlock !== 1'b0 || lock_if.alarm !== 1'b0) $display("FAIL %s first_edge: got unlock=%b alarm=%b want 0/0", tag, lock_if.unlock, lock_if.alarm); else n_pass++;

    if (opens) begin
      for (int i = 0; i < OPEN_C; i++) begin
        noise();
        @(negedge clk);
        n_checks++; if (lock_if.unlock !== 1'b1) $display("FAIL %s open_unlock[%0d]: got %b want 1", tag, i, lock_if.unlock); else n_pass++;
      end
      noise();
      @(negedge clk);
      quiet();
      n_checks++; if (lock_if.unlock !== 1'b0 || lock_if.ready !== 1'b1) $display("FAIL %s open_end: got unlock=%b ready=%b want 0/1", tag, lock_if.unlock, lock_if.ready); else n_pass++;
    end else if (locks) begin
      for (int i = 0; i < LOCK_C; i++) begin
        noise();
        @(negedge clk);
        n_checks++;
        if (lock_if.alarm !== 1'b1 || lock_if.ready !== 1'b0 || lock_if.fail_count !== 2'(MAXF))
          $display("FAIL %s lockout[%0d]: got alarm=%b ready=%b fc=%0d want 1/0/%0d", tag, i, lock_if.alarm, lock_if.ready, lock_if.fail_count, MAXF);
        else n_pass++;
      end
      noise();
      @(negedge clk);
      quiet();
      ref_fails = 0;
      n_checks++;
      if (lock_if.alarm !== 1'b0 || lock_if.ready !== 1'b1 || lock_if.fail_count !== 2'd0)
        $display("FAIL %s lockout_end: got alarm=%b ready=%b fc=%0d want 0/1/0", tag, lock_if.alarm, lock_if.ready, lock_if.fail_count);
      else n_pass++;
    end else begin
      quiet();
      n_checks++; if (lock_if.ready !== 1'b1) $display("FAIL %s back_idle: got ready=%b want 1", tag, lock_if.ready); else n_pass++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    lock_if.prog_mode = 1'b0;
    lock_if.digit_in  = 3'd0;
    quiet();
    ref_code  = '0;
    ref_fails = 0;
    idle(3);
    n_checks++; if (lock_if.ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", lock_if.ready); else n_pass++;
    n_checks++; if (lock_if.unlock !== 1'b0) $display("FAIL reset_unlock: got %b want 0", lock_if.unlock); else n_pass++;
    n_checks++; if (lock_if.alarm !== 1'b0) $display("FAIL reset_alarm: got %b want 0", lock_if.alarm); else n_pass++;
    n_checks++; if (lock_if.fail_count !== 2'd0) $display("FAIL reset_fail_count: got %0d want 0", lock_if.fail_count); else n_pass++;
    rst_n = 1'b1;
    idle(2);
    n_checks++; if (lock_if.ready !== 1'b1 || lock_if.unlock !== 1'b0) $display("FAIL post_reset: got ready=%b unlock=%b want 1/0", lock_if.ready, lock_if.unlock); else n_pass++;
  endtask

  task automatic test_default_code();
    enter_code(mk(0, 0, 0, 0), 2);
    check_outcome(mk(0, 0, 0, 0), "default_code");
  endtask

  task automatic test_program();
    enter_code(ref_code, 2);
    ref_fails = 0;
    idle(2);
    n_checks++; if (lock_if.unlock !== 1'b1) $display("FAIL prog_opened: got %b want 1", lock_if.unlock); else n_pass++;
    lock_if.prog_mode = 1'b1;
    @(negedge clk);
    lock_if.prog_mode = 1'b0;
    n_checks++; if (lock_if.unlock !== 1'b0 || lock_if.ready !== 1'b1) $display("FAIL prog_enter: got unlock=%b ready=%b want 0/1", lock_if.unlock, lock_if.ready); else n_pass++;
    enter_code(mk(5, 3, 7, 1), 2);
    ref_code = mk(5, 3, 7, 1);
    n_checks++; if (lock_if.fail_count !== 2'd0 || lock_if.unlock !== 1'b0) $display("FAIL prog_done: got fc=%0d unlock=%b want 0/0", lock_if.fail_count, lock_if.unlock); else n_pass++;
    idle(1);
    enter_code(mk(5, 3, 7, 1), 1);
    check_outcome(mk(5, 3, 7, 1), "new_code");
    enter_code(mk(5, 3, 7, 2), 1);
    check_outcome(mk(5, 3, 7, 2), "near_miss");
  endtask

  task automatic test_lockout();
    logic [L*3-1:0] c;
    int n;
    n = MAXF - ref_fails;
    for (int i = 0; i < n; i++) begin
      c = wrong_code();
      enter_code(c, 2);
      check_outcome(c, "lockout_try");
    end
    enter_code(ref_code, 1);
    check_outcome(ref_code, "after_lockout");
  endtask

  task automatic test_clear();
    logic [L*3-1:0] c;
    c = wrong_code();
    enter_code(c, 1);
    check_outcome(c, "pre_clear");
    send_digit(3'd5);
    send_digit(3'd3);
    pulse_clear();
    n_checks++; if (lock_if.ready !== 1'b1 || lock_if.fail_count !== 2'(ref_fails)) $display("FAIL clear_abort: got ready=%b fc=%0d want 1/%0d", lock_if.ready, lock_if.fail_count, ref_fails); else n_pass++;
    enter_code(ref_code, 1);
    check_outcome(ref_code, "after_clear");
    send_digit(3'd5);
    send_digit(3'd3);
    lock_if.clear = 1'b1;
    send_digit(3'd7);
    lock_if.clear = 1'b0;
    n_checks++; if (lock_if.ready !== 1'b1 || lock_if.unlock !== 1'b0) $display("FAIL clear_with_digit: got ready=%b unlock=%b want 1/0", lock_if.ready, lock_if.unlock); else n_pass++;
    enter_code(ref_code, 1);
    check_outcome(ref_code, "clear_wins");
  endtask

  task automatic test_random();
    logic [L*3-1:0] c;
    int k;
    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        k = int'($urandom_range(1, L - 1));
        for (int i = 0; i < k; i++) send_digit(3'($urandom));
        pulse_clear();
      end
      c = ($urandom_range(0, 9) < 4) ? ref_code : 12'($urandom);
      enter_code(c, 3);
      check_outcome(c, "random");
    end
  endtask

  task automatic test_reset_mid();
    logic [L*3-1:0] c;
    int n;
    n = MAXF - ref_fails - 1;
    for (int i = 0; i < n; i++) begin
      c = wrong_code();
      enter_code(c, 1);
      check_outcome(c, "pre_reset");
    end
    enter_code(wrong_code(), 1);
    idle(5);
    n_checks++; if (lock_if.alarm !== 1'b1) $display("FAIL mid_lockout_alarm: got %b want 1", lock_if.alarm); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (lock_if.alarm !== 1'b0 || lock_if.ready !== 1'b1 || lock_if.fail_count !== 2'd0)
      $display("FAIL reset_lockout: got alarm=%b ready=%b fc=%0d want 0/1/0", lock_if.alarm, lock_if.ready, lock_if.fail_count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    ref_code  = '0;
    ref_fails = 0;
    exp_q.delete();
    enter_code(ref_code, 1);
    idle(2);
    lock_if.prog_mode = 1'b1;
    @(negedge clk);
    lock_if.prog_mode = 1'b0;
    send_digit(3'd3);
    send_digit(3'd6);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (lock_if.ready !== 1'b1 || lock_if.unlock !== 1'b0) $display("FAIL reset_prog: got ready=%b unlock=%b want 1/0", lock_if.ready, lock_if.unlock); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    enter_code(mk(0, 0, 0, 0), 1);
    check_outcome(mk(0, 0, 0, 0), "zero_after_reset");
  endtask

  initial begin
    test_reset();
    test_default_code();
    test_program();
    test_lockout();
    test_clear();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/code_lock_controller.md
CODE_LOCK_CONTROLLER -- requirements
Module: code_lock_controller

Interface
REQ-001 Parameter CODE_LEN, default 4, number of 3-bit digits per code (2..8).
REQ-002 Parameter OPEN_CYCLES, default 8, cycles unlock stays high.
REQ-003 Parameter MAX_FAILS, default 3, consecutive failed attempts that trigger lockout (1..3).
REQ-004 Parameter LOCKOUT_CYCLES, default 16, cycles alarm stays high.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 digit_in  input  3  entered digit, sampled only when digit_valid=1.
REQ-008 digit_valid  input  1  one-cycle strobe, one digit per high cycle.
REQ-009 clear  input  1  synchronous abort of a partial entry.
REQ-010 prog_mode  input  1  level, requests code reprogramming while open.
REQ-011 ready  output  1  high when a digit_valid will be consumed.
REQ-012 unlock  output  1  registered, high while lock is open.
REQ-013 alarm  output  1  registered, high during lockout.
REQ-014 fail_count  output  2  consecutive failed attempts.

Function
REQ-015 States: IDLE, ENTER, CHECK, OPEN, PROG, LOCKOUT; the encoding is fixed in the package.
REQ-016 IDLE: digit_valid -> ENTER, digit consumed as index 0, idx<=1.
REQ-017 ENTER: each digit_valid compared with stored[idx] through the single shared comparator; any mismatch sets a sticky mismatch flag; idx increments.
REQ-018 ENTER: when the digit at idx=CODE_LEN-1 is consumed -> CHECK next cycle; idx<=0.
REQ-019 CHECK lasts exactly one cycle; match -> OPEN, fail_count<=0; mismatch -> fail_count+1, then LOCKOUT if new count = MAX_FAILS, else IDLE.
REQ-020 Latency: unlock or alarm rises on the 2nd rising edge after the edge sampling the last digit.
REQ-021 OPEN: unlock=1 for OPEN_CYCLES cycles (timer counts down), then IDLE; digit_valid ignored unless prog_mode=1.
REQ-022 OPEN with prog_mode=1: -> PROG next cycle, unlock<=0, idx<=0, timer discarded.
REQ-023 PROG: each digit_valid writes stored[idx]; after index CODE_LEN-1 is written -> IDLE; no compare, fail_count unchanged.
REQ-024 LOCKOUT: alarm=1 for LOCKOUT_CYCLES cycles, all digit_valid and clear ignored; on expiry fail_count<=0, -> IDLE.
REQ-025 clear in IDLE or ENTER: -> IDLE, idx<=0, mismatch flag<=0, fail_count unchanged; clear ignored in CHECK, OPEN, PROG, LOCKOUT.
REQ-026 clear and digit_valid in the same ENTER cycle: clear wins, digit discarded.
REQ-027 ready = 1 in IDLE, ENTER, PROG only; digit_valid with ready=0 is dropped with no side effect.
REQ-028 idx, timer and fail_count never wrap: they saturate or reload exactly as above.
REQ-029 Equality is bitwise on all 3 bits.

Reset
REQ-030 rst_n low asynchronously forces IDLE, idx=0, mismatch=0, timer=0, fail_count=0, unlock=0, alarm=0, ready=1.
REQ-031 The stored code resets to all digits 0.
REQ-032 Reset in any state, including mid-entry, OPEN, PROG or LOCKOUT, takes effect immediately; a partial PROG write leaves the stored code at its reset value.

Structure
REQ-033 The package holds the state encoding localparams, the digit width (3) and the default parameter values.
REQ-034 One sub-module, comparador_digito_3bits (3-bit equality, combinational), is instantiated exactly once.

Verification
REQ-035 After reset, enter 0,0,0,0 -> unlock high 2 edges after the 4th strobe, for 8 cycles, then ready=1.
REQ-036 While open, prog_mode=1 with 5,3,7,1 programmed; then entering 5,3,7,1 -> unlock; entering 5,3,7,2 -> unlock=0, fail_count=1.
REQ-037 Three wrong codes -> alarm=1 for 16 cycles, fail_count=3, strobes ignored, then fail_count=0 and ready=1.
REQ-038 Digits 5,3 then clear, then 5,3,7,1 -> unlock, fail_count=0; clear and digit_valid in the same cycle -> digit discarded.
REQ-039 rst_n pulsed low mid-LOCKOUT and mid-PROG -> alarm=0 and IDLE immediately; code 0,0,0,0 unlocks.
